// File: rtl/vernier_tdc_pkg.sv
// Shared types and constants for the vernier TDC readout sequencer.
package vernier_tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SETTLE,
        CAPTURE,
        CONVERT,
        HOLD
    } state_t;

    localparam int CLEAR_CYC   = 2;
    localparam int SYNC_STAGES = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/vernier_therm2bin.sv
// Fine thermometer to binary: index of the lowest zero bit, N_FINE if all ones.
// Optional majority bubble filter enabled by `BUBBLE_FIX_EN.
module vernier_therm2bin
    import vernier_tdc_pkg::*;
#(
    parameter int N_FINE = 8,
    parameter int FW     = $clog2(N_FINE) + 1
) (
    input  logic [N_FINE-1:0] therm,
    output logic [FW-1:0]     fine
);

    logic [N_FINE-1:0] fixed;

`ifdef BUBBLE_FIX_EN
    // Edge bits are replicated so each end sees itself as its missing neighbour.
    logic [N_FINE+1:0] pad;
    assign pad = {therm[N_FINE-1], therm, therm[0]};

    for (genvar i = 0; i < N_FINE; i++) begin : g_maj
        assign fixed[i] = maj3(pad[i], pad[i+1], pad[i+2]);
    end
`else
    assign fixed = therm;
`endif

    always_comb begin
        fine = FW'(N_FINE);
        for (int i = N_FINE - 1; i >= 0; i--) begin
            if (!fixed[i]) fine = FW'(i);
        end
    end

endmodule

// File: rtl/vernier_tdc_readout.sv
// Sequencer/decoder for the vernier loop: clear, arm, wait for stop, capture, convert,
// and hand one TDC word to the back-end. Build option: `BUBBLE_FIX_EN (in vernier_therm2bin).
module vernier_tdc_readout
    import vernier_tdc_pkg::*;
#(
    parameter  int B_COUNT     = 1,
    parameter  int N_FINE      = 8,
    parameter  int SETTLE_CYC  = 2,
    parameter  int TIMEOUT_CYC = 255,
    localparam int RES_W       = B_COUNT + $clog2(N_FINE) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               mux_loop_i,
    input  logic [B_COUNT-1:0] loop_count_i,
    input  logic               stop_i,
    input  logic [N_FINE-1:0]  fine_therm_i,
    output logic               loop_rst_o,
    output logic               busy_o,
    output logic [RES_W-1:0]   result_o,
    output logic               timeout_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int FW   = $clog2(N_FINE) + 1;
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int PMAX = (CLEAR_CYC > SETTLE_CYC) ? CLEAR_CYC : SETTLE_CYC;
    localparam int PW   = $clog2(PMAX + 1);

    typedef struct packed {
        logic               mux;
        logic [B_COUNT-1:0] count;
        logic [N_FINE-1:0]  therm;
    } cap_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] stop_sync;
    logic [SYNC_STAGES-1:0] mux_sync;
    logic [TW-1:0]          tmo_cnt;
    logic [PW-1:0]          ph_cnt;
    cap_t                   cap;
    logic [FW-1:0]          fine;
    logic [RES_W-1:0]       coarse;
    logic [RES_W-1:0]       conv;

    vernier_therm2bin #(
        .N_FINE (N_FINE),
        .FW     (FW)
    ) u_therm2bin (
        .therm (cap.therm),
        .fine  (fine)
    );

    // Coarse count only counts when the loop actually wrapped through the mux.
    always_comb begin
        coarse = cap.mux ? RES_W'(cap.count) : '0;
        conv   = coarse * RES_W'(N_FINE) + RES_W'(fine);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            loop_rst_o <= 1'b1;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            timeout_o  <= 1'b0;
            result_o   <= '0;
            stop_sync  <= '0;
            mux_sync   <= '0;
            tmo_cnt    <= '0;
            ph_cnt     <= '0;
            cap        <= '0;
        end else begin
            stop_sync <= {stop_sync[SYNC_STAGES-2:0], stop_i};
            mux_sync  <= {mux_sync[SYNC_STAGES-2:0], mux_loop_i};
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= CLEAR;
                        busy_o <= 1'b1;
                        ph_cnt <= '0;
                    end
                end
                CLEAR: begin
                    // Flush stale stop/mux levels from a previous run.
                    stop_sync <= '0;
                    mux_sync  <= '0;
                    tmo_cnt   <= '0;
                    ph_cnt    <= ph_cnt + 1'b1;
                    if (ph_cnt == PW'(CLEAR_CYC - 1)) begin
                        state      <= MEASURE;
                        loop_rst_o <= 1'b0;
                    end
                end
                MEASURE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (stop_sync[SYNC_STAGES-1]) begin
                        state  <= SETTLE;
                        ph_cnt <= '0;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state      <= HOLD;
                        loop_rst_o <= 1'b1;
                        valid_o    <= 1'b1;
                        timeout_o  <= 1'b1;
                        result_o   <= '1;
                    end
                end
                SETTLE: begin
                    ph_cnt <= ph_cnt + 1'b1;
                    if (ph_cnt == PW'(SETTLE_CYC - 1)) state <= CAPTURE;
                end
                CAPTURE: begin
                    cap   <= '{mux: mux_sync[SYNC_STAGES-1], count: loop_count_i, therm: fine_therm_i};
                    state <= CONVERT;
                end
                CONVERT: begin
                    result_o   <= conv;
                    timeout_o  <= 1'b0;
                    valid_o    <= 1'b1;
                    loop_rst_o <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vernier_tdc_readout.sv
// Directed bench for vernier_tdc_readout (B_COUNT=4, N_FINE=8, SETTLE_CYC=2, TIMEOUT_CYC=255).
module tb_vernier_tdc_readout;

    localparam int B_COUNT = 4;
    localparam int N_FINE  = 8;
    localparam int RES_W   = B_COUNT + $clog2(N_FINE) + 1;

    logic               clk = 1'b0;
    logic               rst, start_i, mux_loop_i, stop_i, ready_i;
    logic [B_COUNT-1:0] loop_count_i;
    logic [N_FINE-1:0]  fine_therm_i;
    logic               loop_rst_o, busy_o, timeout_o, valid_o;
    logic [RES_W-1:0]   result_o;

    int n_chk  = 0;
    int n_fail = 0;

    vernier_tdc_readout #(
        .B_COUNT     (B_COUNT),
        .N_FINE      (N_FINE),
        .SETTLE_CYC  (2),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mux_loop_i   (mux_loop_i),
        .loop_count_i (loop_count_i),
        .stop_i       (stop_i),
        .fine_therm_i (fine_therm_i),
        .loop_rst_o   (loop_rst_o),
        .busy_o       (busy_o),
        .result_o     (result_o),
        .timeout_o    (timeout_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start for one cycle; cyc returns edges from the start edge until valid_o.
    task automatic start_and_wait(input int stop_after, input int bound, output int cyc);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        cyc = 1;
        while (!valid_o && cyc < bound) begin
            if (stop_after >= 0 && cyc == stop_after) stop_i = 1'b1;
            tick(1);
            cyc++;
        end
        chk("valid_seen", valid_o, 1);
        stop_i = 1'b0;
    endtask

    task automatic accept();
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        chk("accept_valid", valid_o, 0);
        chk("accept_busy", busy_o, 0);
    endtask

    task automatic set_in(input logic mux, input logic [B_COUNT-1:0] cnt, input logic [N_FINE-1:0] th);
        mux_loop_i   = mux;
        loop_count_i = cnt;
        fine_therm_i = th;
    endtask

    initial begin
        int cyc;
        int nvalid;
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b0;
        set_in(1'b0, '0, '0);
        tick(3);
        rst = 1'b0;
        chk("rst_loop_rst", loop_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_result", result_o, 0);

        // Coarse 3, fine 3 -> 27; then backpressure.
        set_in(1'b1, 4'd3, 8'b0000_0111);
        start_and_wait(6, 60, cyc);
        chk("t2_result", result_o, 27);
        chk("t2_timeout", timeout_o, 0);
        chk("t2_loop_rst", loop_rst_o, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t2_hold_valid", valid_o, 1);
            chk("t2_hold_result", result_o, 27);
        end
        accept();

        // Reset during MEASURE.
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(6);
        chk("t1_busy_meas", busy_o, 1);
        chk("t1_loop_rst_meas", loop_rst_o, 0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("t1_loop_rst", loop_rst_o, 1);
        chk("t1_busy", busy_o, 0);
        chk("t1_valid", valid_o, 0);
        chk("t1_result", result_o, 0);
        tick(2);
        chk("t1_idle_busy", busy_o, 0);

        // No stop: timeout after TIMEOUT_CYC measure cycles (2 clear + 1 entry).
        start_and_wait(-1, 400, cyc);
        chk("t3_latency", cyc, 258);
        chk("t3_timeout", timeout_o, 1);
        chk("t3_result", result_o, 255);
        accept();

        // mux_loop low masks the coarse count.
        set_in(1'b0, 4'd5, 8'b0000_0011);
        start_and_wait(5, 60, cyc);
        chk("t4_result", result_o, 2);
        chk("t4_timeout", timeout_o, 0);
        accept();

        // Bubbled thermometer.
        set_in(1'b1, 4'd0, 8'b0001_1011);
        start_and_wait(5, 60, cyc);
`ifdef BUBBLE_FIX_EN
        chk("t5_result", result_o, 5);
`else
        chk("t5_result", result_o, 2);
`endif
        accept();

        // start_i ignored in MEASURE and HOLD.
        set_in(1'b1, 4'd1, 8'b0011_1111);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(5);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        stop_i = 1'b1;
        cyc = 0;
        while (!valid_o && cyc < 60) begin
            tick(1);
            cyc++;
        end
        stop_i = 1'b0;
        chk("t6_valid", valid_o, 1);
        chk("t6_result", result_o, 14);
        start_i = 1'b1;
        tick(2);
        start_i = 1'b0;
        chk("t6_hold_valid", valid_o, 1);
        accept();
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (valid_o || busy_o) nvalid++;
        end
        chk("t6_no_extra", nvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
